mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Scan sequencer that sits directly upstream of the 4:1 select mux, driving its `s0`/`s1` select lines and consuming its single-bit `out`. The block steps through all four channels, holds each select for a programmable settle time, samples the mux output, and presents the assembled 4-bit frame downstream on a valid/ready handshake. It supports single-shot and continuous scanning, and raises a sticky overrun flag when a frame is lost.

## Interface
- `DWELL`, default 2: cycles each channel select is held before sampling. Legal range is 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  scan request. Sampled only in IDLE.
- `cont`  in  1  continuous mode (level). Sampled at each frame completion.
- `mux_out`  in  1  output of the downstream 4:1 mux.
- `s0`  out  1  mux select MSB (channel pair). Registered.
- `s1`  out  1  mux select LSB (channel within pair). Registered.
- `frame`  out  4  captured frame. `frame[i]` holds channel i.
- `frame_valid`  out  1  frame available.
- `frame_ready`  in  1  downstream accepts the frame.
- `busy`  out  1  scan in progress (state SCAN).
- `overrun`  out  1  sticky: a completed frame was dropped.

## Operation
- Channel index `ch` = {`s0`,`s1`}. Channel 0 selects i0, 1 selects i1, 2 selects i2, 3 selects i3.
- States: IDLE and SCAN. An 8-bit dwell counter `dcnt`, a 2-bit `ch`, and a 3-bit shadow register for channels 0..2.
- IDLE:
  - `s0`=`s1`=0, `busy`=0.
  - On `start`=1: go to SCAN with `ch`=0, `dcnt`=0, and clear `overrun`.
- SCAN, each cycle:
  - If `dcnt`≠DWELL-1: `dcnt`++.
  - Otherwise, sample `mux_out`, set `dcnt`=0, and advance `ch`.
    - For `ch`<3: store the sample to `shadow[ch]`; `ch`++.
    - For `ch`=3: this is frame completion (see below).
- Frame completion (sample of ch3):
  - Candidate frame = {`mux_out`, `shadow[2]`, `shadow[1]`, `shadow[0]`}.
  - If `frame_valid`=0, or `frame_valid`&&`frame_ready` on the same edge: load `frame` and set `frame_valid`=1.
  - Otherwise, drop the candidate, leave `frame` unchanged, and set `overrun`=1.
  - Then, if `cont`=1: `ch` wraps to 0 and SCAN continues with no gap cycle.
  - If `cont`=0: go to IDLE and `ch`=0.
- Handshake:
  - `frame_valid` clears on the edge where `frame_valid`&&`frame_ready`, unless a new frame loads on that edge.
  - `frame` is stable while `frame_valid`=1 and not accepted.
  - `frame_ready` has no effect when `frame_valid`=0.
- `start` in SCAN is ignored.
- Deasserting `cont` mid-scan finishes the current frame, then goes to IDLE.
- `overrun` stays at 1 until reset or until the next accepted `start`.

## Timing
- Reset (async assert, sync release by the system):
  - `s0`=`s1`=0, `frame`=0, `frame_valid`=0, `busy`=0, `overrun`=0.
  - State IDLE, `dcnt`=0, shadow=0.
- Reset mid-scan discards the partial frame immediately.
- Start edge E: `busy`=1 and select=0 after E.
- Select for channel k is held for exactly DWELL cycles, starting after edge E+k·DWELL.
- The sample of channel k is taken at edge E+(k+1)·DWELL. `mux_out` must be settled before that edge.
- `frame_valid` rises after edge E+4·DWELL. Start-to-valid latency is 4·DWELL cycles.
- Single-shot: `busy` falls after the same edge where `frame_valid` rises.
- Continuous: one frame every 4·DWELL cycles. The downstream must accept within that window to avoid overrun.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- **Single-shot, DWELL=2.** Mux inputs i0..i3 = 1,0,1,1; `start` pulse at cycle 0.
  - Select sequence 00,00,01,01,10,10,11,11.
  - `frame`=4'b1101, `frame_valid` at cycle 8, `busy` low from cycle 8.
  - `frame_ready`=1 at cycle 10 clears `frame_valid` at cycle 11.
- **Continuous, DWELL=1, `frame_ready` tied high.** Inputs change each frame: 4'b0101, then 4'b1010.
  - Back-to-back frames every 4 cycles, frames match the inputs, no gap in the select sequence, `overrun`=0.
- **Overrun.** Continuous mode, DWELL=1, `frame_ready`=0.
  - First frame held.
  - Second completion sets `overrun`=1 with `frame` unchanged.
  - A later `start` after returning to IDLE clears `overrun`.
- **Simultaneous accept and complete.** `frame_ready` pulses on exactly the completion edge of frame 2.
  - `frame_valid` stays 1, `frame` updates to frame 2, `overrun`=0.
- **Reset mid-scan.** `rst_n` asserted during ch2 dwell.
  - All outputs go to reset values immediately.
  - After release, `start` yields a correct fresh frame with no stale shadow bits.
- **`start` while busy, and `cont` drop.** Pulse `start` mid-scan; deassert `cont` mid-frame.
  - The `start` is ignored.
  - The current frame completes, then the block goes to IDLE with `s0`=`s1`=0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 select mux: steps the selects through channels 0..3,
// samples the mux output after a programmable dwell and emits a 4-bit frame.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic       overrun,
  output logic       dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     r_state;
  logic [7:0] r_dcnt;
  logic [1:0] r_ch;
  logic [2:0] r_shadow;
  logic [3:0] r_frame;
  logic       r_frame_valid;
  logic       r_overrun;

  state_t     w_state_nxt;
  logic [7:0] w_dcnt_nxt;
  logic [1:0] w_ch_nxt;
  logic [2:0] w_shadow_nxt;
  logic [3:0] w_frame_nxt;
  logic       w_frame_valid_nxt;
  logic       w_overrun_nxt;
  logic       w_accept;

  // Handshake: a frame transfers on any edge where frame_valid && frame_ready.
  // frame holds while valid and not accepted; a completion arriving on an
  // accept edge replaces the frame, otherwise a completion while valid drops.
  assign w_accept = r_frame_valid & frame_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_dcnt_nxt        = r_dcnt;
    w_ch_nxt          = r_ch;
    w_shadow_nxt      = r_shadow;
    w_frame_nxt       = r_frame;
    w_frame_valid_nxt = r_frame_valid;
    w_overrun_nxt     = r_overrun;

    if (w_accept) begin
      w_frame_valid_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        w_dcnt_nxt = 8'd0;
        w_ch_nxt   = 2'd0;
        if (start) begin
          w_state_nxt   = ST_SCAN;
          w_overrun_nxt = 1'b0;
        end
      end
      ST_SCAN: begin
        if (r_dcnt != DWELL_LAST) begin
          w_dcnt_nxt = r_dcnt + 8'd1;
        end else begin
          w_dcnt_nxt = 8'd0;
          case (r_ch)
            2'd0: w_shadow_nxt[0] = mux_out;
            2'd1: w_shadow_nxt[1] = mux_out;
            2'd2: w_shadow_nxt[2] = mux_out;
            default: begin
              if (!r_frame_valid || w_accept) begin
                w_frame_nxt       = {mux_out, r_shadow};
                w_frame_valid_nxt = 1'b1;
              end else begin
                w_overrun_nxt = 1'b1;
              end
              if (!cont) begin
                w_state_nxt = ST_IDLE;
              end
            end
          endcase
          // ch3 wraps to 0, giving back-to-back frames in continuous mode
          w_ch_nxt = r_ch + 2'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_dcnt        <= 8'd0;
      r_ch          <= 2'd0;
      r_shadow      <= 3'd0;
      r_frame       <= 4'd0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dcnt        <= w_dcnt_nxt;
      r_ch          <= w_ch_nxt;
      r_shadow      <= w_shadow_nxt;
      r_frame       <= w_frame_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  assign s0          = r_ch[1];
  assign s1          = r_ch[0];
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign busy        = (r_state == ST_SCAN);
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a 4:1 mux model feeds the DUT; a frame-level reference
// (select = phase / DWELL, one-slot output buffer) predicts every cycle.
module tb_mux_scan_ctrl;
  localparam int D  = 2;
  localparam int FL = 4 * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       frame_ready = 1'b0;
  logic [3:0] mux_in = 4'd0;

  logic       mux_out;
  logic       s0, s1, fv, busy, ovr, dbg;
  logic [3:0] frame;

  int n_cmp = 0;
  int n_err = 0;

  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_busy = 1'b0;
  logic [3:0] m_frame = 4'd0;
  logic [3:0] frm_in[0:15];

  assign mux_out = mux_in[{s0, s1}];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mux_out(mux_out),
    .s0(s0), .s1(s1), .frame(frame), .frame_valid(fv), .frame_ready(frame_ready),
    .busy(busy), .overrun(ovr), .dbg_state(dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},   {6'd0, s0, s1}, 8'd0);
    chk({tag, "_frame"}, {4'd0, frame}, 8'd0);
    chk({tag, "_fv"},    {7'd0, fv}, 8'd0);
    chk({tag, "_busy"},  {7'd0, busy}, 8'd0);
    chk({tag, "_ovr"},   {7'd0, ovr}, 8'd0);
  endtask

  // rmode: 0 never ready, 1 always, 2 random, 3 only on frame-2 completion, 4 one pulse after frame 1
  task automatic run_scan(input string tag, input int nfr, input int rmode, input int tail,
                          input logic [3:0] in0, input logic [3:0] in1, input bit poke);
    logic       rdy, acc, load, cdrv;
    logic [1:0] sel_exp;
    int         f;
    for (int t = 0; t <= nfr * FL + tail; t++) begin
      start = (t == 0) || (poke && t == D + 1);
      cdrv  = (t < (nfr - 1) * FL + D);
      cont  = cdrv;
      case (rmode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        3:       rdy = (t == 2 * FL);
        default: rdy = (t == FL + 3);
      endcase
      frame_ready = rdy;
      if (t == 0) begin
        mux_in    = in0;
        frm_in[0] = in0;
      end else if ((t - 1) % FL == 0 && (t - 1) / FL < nfr && (t - 1) / FL > 0) begin
        f         = (t - 1) / FL;
        mux_in    = (f == 1) ? in1 : 4'($urandom);
        frm_in[f] = mux_in;
      end

      acc  = m_valid && rdy;
      load = 1'b0;
      if (t == 0) begin
        m_busy = 1'b1;
        m_ovr  = 1'b0;
      end else if (m_busy && t % FL == 0) begin
        if (!m_valid || acc) begin
          m_frame = frm_in[t / FL - 1];
          load    = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        if (!cdrv) m_busy = 1'b0;
      end
      if (load) m_valid = 1'b1;
      else if (acc) m_valid = 1'b0;
      sel_exp = m_busy ? 2'((t % FL) / D) : 2'd0;

      tick();
      chk({tag, "_sel"},   {6'd0, s0, s1}, {6'd0, sel_exp});
      chk({tag, "_busy"},  {7'd0, busy}, {7'd0, m_busy});
      chk({tag, "_fv"},    {7'd0, fv}, {7'd0, m_valid});
      chk({tag, "_frame"}, {4'd0, frame}, {4'd0, m_frame});
      chk({tag, "_ovr"},   {7'd0, ovr}, {7'd0, m_ovr});
    end
    start       = 1'b0;
    cont        = 1'b0;
    frame_ready = 1'b0;
  endtask

  initial begin
    // reset
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_async");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_reset_vals("rst_idle");

    // single-shot, inputs i0..i3 = 1,0,1,1
    run_scan("single", 1, 4, 5, 4'b1101, 4'b0000, 1'b0);
    chk("single_frame_val", {4'd0, frame}, 8'h0d);

    // continuous, ready always high, 0101 then 1010
    run_scan("cont", 4, 1, 3, 4'b0101, 4'b1010, 1'b0);

    // overrun with ready low, then a new start clears it
    run_scan("ovr", 3, 0, 3, 4'b0110, 4'b1001, 1'b0);
    chk("ovr_sticky", {7'd0, ovr}, 8'd1);
    chk("ovr_frame_held", {4'd0, frame}, 8'h06);
    run_scan("restart", 1, 1, 3, 4'b0011, 4'b0000, 1'b0);
    chk("restart_ovr_clr", {7'd0, ovr}, 8'd0);

    // accept on exactly the frame-2 completion edge
    run_scan("simul", 2, 3, 3, 4'b1110, 4'b0111, 1'b0);
    chk("simul_fv", {7'd0, fv}, 8'd1);
    chk("simul_frame", {4'd0, frame}, 8'h07);
    chk("simul_ovr", {7'd0, ovr}, 8'd0);

    // start while busy plus cont drop, random ready
    run_scan("poke", 5, 2, 4, 4'($urandom), 4'($urandom), 1'b1);

    // reset during ch2 dwell, then a clean fresh frame
    mux_in = 4'hf;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * D) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    m_valid = 1'b0;
    m_frame = 4'd0;
    m_ovr   = 1'b0;
    m_busy  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_scan("fresh", 1, 0, 2, 4'h0, 4'h0, 1'b0);
    chk("fresh_fv", {7'd0, fv}, 8'd1);
    run_scan("fresh2", 1, 1, 2, 4'b0100, 4'h0, 1'b0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      run_scan("rand", $urandom_range(1, 4), 2, $urandom_range(1, 5),
               4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
